// File: rtl/bitwise_seq_unit_if.sv
// rtl/bitwise_seq_unit_if.sv - operand/result bundle for bitwise_seq_unit
// Optional parity signal present when BITWISE_SEQ_PARITY_EN is defined.
interface bitwise_seq_unit_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    ones_cnt;
`ifdef BITWISE_SEQ_PARITY_EN
    logic             parity;

    modport master (output start, op, a, b, input busy, done, result, ones_cnt, parity);
    modport slave  (input start, op, a, b, output busy, done, result, ones_cnt, parity);
`else
    modport master (output start, op, a, b, input busy, done, result, ones_cnt);
    modport slave  (input start, op, a, b, output busy, done, result, ones_cnt);
`endif
endinterface

// File: rtl/bitwise_seq_unit.sv
// rtl/bitwise_seq_unit.sv - iterative AND/OR/XOR/XNOR unit with popcount, BPC bits per clock
// Optional parity output guarded by BITWISE_SEQ_PARITY_EN.
module bitwise_seq_unit #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bitwise_seq_unit_if.slave bus
);
    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_cfg
            $error("bitwise_seq_unit: WIDTH must be >= 2 and a multiple of BPC");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    ones_q, ones_d;

    logic [31:0]      base;
    logic [BPC-1:0]   a_sl, b_sl, chunk;
    logic [CW-1:0]    chunk_ones;
    logic             last_step;

    // Slice of the captured operands handled on this edge, and its 1-count.
    always_comb begin
        base = 32'(idx_q) * BPC;
        a_sl = a_q[base +: BPC];
        b_sl = b_q[base +: BPC];
        case (op_q)
            2'b00:   chunk = a_sl & b_sl;
            2'b01:   chunk = a_sl | b_sl;
            2'b10:   chunk = a_sl ^ b_sl;
            default: chunk = ~(a_sl ^ b_sl);
        endcase
        chunk_ones = '0;
        for (int i = 0; i < BPC; i++) begin
            chunk_ones = chunk_ones + CW'(chunk[i]);
        end
        last_step = (idx_q == IW'(STEPS - 1));
    end

`ifdef BITWISE_SEQ_PARITY_EN
    logic parity_q, parity_d;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ones_d   = ones_q;
`ifdef BITWISE_SEQ_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_RUN: begin
                shadow_d[base +: BPC] = chunk;
                cnt_d = cnt_q + chunk_ones;
                if (last_step) begin
                    result_d = shadow_d;
                    ones_d   = cnt_d;
`ifdef BITWISE_SEQ_PARITY_EN
                    parity_d = ^shadow_d;
`endif
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A start in DONE relaunches directly; in RUN it is ignored.
        if ((state_q == S_IDLE || state_q == S_DONE) && bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b;
            op_d    = bus.op;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ones_q   <= '0;
`ifdef BITWISE_SEQ_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ones_q   <= ones_d;
`ifdef BITWISE_SEQ_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.ones_cnt = ones_q;
`ifdef BITWISE_SEQ_PARITY_EN
    assign bus.parity   = parity_q;
`endif
endmodule

// File: doc/bitwise_seq_unit.md
Name: bitwise_seq_unit

Overview:
- Parametrised, clocked bitwise logic unit. Replaces the fixed 4-bit combinational XOR.
- Operands are WIDTH bits wide. The operation (AND/OR/XOR/XNOR) is selected at run time.
- Evaluation is iterative, BPC bits per clock, under a start/busy/done handshake.
- Also reports the popcount of the result; for XOR this is the Hamming distance.
- Used as a lab datapath block between operand registers and display/compare logic.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- BPC, 1, bits evaluated per clock; WIDTH must be an exact multiple of BPC (checked by an elaboration-time error).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; sampled on the rising edge of clk.
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and ones_cnt are valid from this cycle.
- result  output  WIDTH  bitwise op(a, b).
- ones_cnt  output  CW  number of 1 bits in result, where CW = $clog2(WIDTH+1).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, ones_cnt=0; internal index, operand and count registers cleared. Takes effect immediately, including mid-operation; the partial result is discarded.
- STEPS = WIDTH/BPC.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, capture a, b, op into internal registers, clear index and the partial count, go to RUN.
- RUN:
  - Each edge evaluates bits [index*BPC +: BPC] of the captured operands, writes them to the shadow result and adds their 1-count to the partial count, then increments index.
  - On the edge that processes step STEPS-1, copy shadow to result and count to ones_cnt, then go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - If start=1 in this cycle, capture new operands and go to RUN (back-to-back ops, no idle bubble). Otherwise go to IDLE.
- busy=1 exactly while state==RUN.
- Latency: done is high in the cycle following the STEPS-th edge after the capture edge. For WIDTH=8, BPC=1, done rises 8 edges after the capture edge.
- start while in RUN is ignored; it is neither queued nor able to corrupt the operation.
- a, b and op may change freely after the capture edge; only the captured values are used.
- result and ones_cnt change only on the transition into DONE and are held until the next completion or reset.
- ones_cnt range is 0..WIDTH with no overflow; CW is sized to hold WIDTH.
- Index is internal and never exceeds STEPS-1 (no wrap).

Optional Feature:
- Macro: BITWISE_SEQ_PARITY_EN.
- Defined:
  - Extra output port parity (1 bit) equal to the XOR-reduction of result.
  - Updated together with result, reset to 0, held otherwise.
  - Equals ones_cnt[0].
- Undefined: the port does not exist and no parity logic is generated.

Test Plan:
1. WIDTH=8, BPC=1. Reset asserted, then released, then start with a=8'hA5, b=8'h0F, op=10 (XOR). Expect: busy high for 8 cycles, then done pulses once with result=8'hAA, ones_cnt=4 (parity=0 when enabled).
2. Same operands, one operation per op code:
   - op=00 (AND): result=8'h05, ones_cnt=2.
   - op=01 (OR): result=8'hAF, ones_cnt=6.
   - op=11 (XNOR): result=8'h55, ones_cnt=4.
3. a=b=8'hFF with XOR: result=8'h00, ones_cnt=0. Then a=8'h00, b=8'hFF with XOR: result=8'hFF, ones_cnt=8 (boundary values of the count).
4. Start while busy:
   - Launch a=8'h3C, b=8'hC3 with XOR.
   - Pulse start with different operands at RUN cycle 3.
   - Expect no effect: single done, result=8'hFF, ones_cnt=8.
   - Change a and b mid-RUN: the result must still reflect the captured operands.
5. Back-to-back and reset mid-operation:
   - Hold start=1 through the DONE cycle with new operands: expect the next done exactly 9 cycles after the first done (STEPS+1).
   - Assert rst_n=0 mid-RUN: expect busy, done, result and ones_cnt at 0 immediately (asynchronously); no done after release until a new start.
6. WIDTH=16, BPC=4. a=16'h1234, b=16'hFFFF with XOR. Expect done 4 edges after capture, result=16'hEDCB, ones_cnt=11.
